fetch_program_counter: RTL and testbench
========================================

Name: fetch_program_counter

Overview:
Parametrised instruction-fetch program counter. It is the next generation of the fixed thumb-mode PC.
- Adds configurable address width, reset vector and instruction size.
- Adds branch/redirect handling with target alignment checking.
- Adds a post-redirect bubble window while instruction memory refetches.
- Sits at the head of the fetch stage and drives the instruction memory address and the fetch valid bit.

Parameters:
ADDR_WIDTH, 32, width of program_counter_o and branch_target_i
RESET_ADDR, 0, PC value loaded on reset (must be INSTR_BYTES-aligned)
INSTR_BYTES, 2, sequential increment; power of two, 2 or 4
REDIRECT_BUBBLES, 1, invalid fetch cycles after a redirect, range 0..15
BOOT_WAIT, 0, invalid cycles after reset deassertion before the first valid fetch, range 0..15

Ports:
clk_i  input  1  clock; all state updates on posedge
reset_i  input  1  synchronous, active-high reset
stall_pipeline_i  input  stall_pipeline_sig  STALL_PIPELINE freezes sequential advance
branch_valid_i  input  1  redirect request this cycle
branch_target_i  input  ADDR_WIDTH  redirect destination
program_counter_o  output  ADDR_WIDTH  current fetch address (registered)
is_valid_o  output  1  fetch at program_counter_o is architecturally valid
misaligned_o  output  1  one-cycle pulse: last accepted target had nonzero low bits

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on reset_i.
- Reset values:
  - program_counter_o=RESET_ADDR, misaligned_o=0.
  - State=BOOT with count=BOOT_WAIT; if BOOT_WAIT==0, state=RUN.
  - is_valid_o is combinational from state: 1 only in RUN. It is therefore 0 during reset-applied cycles only if BOOT_WAIT>0; otherwise it is 1 from the first cycle after reset.
- States: BOOT, RUN, FLUSH. A 4-bit down-counter is shared by BOOT and FLUSH.
- Sequential advance (RUN, no redirect):
  - If stall_pipeline_i==STALL_PIPELINE, the PC holds.
  - Otherwise PC <= PC + INSTR_BYTES, computed modulo 2^ADDR_WIDTH. Wrap from all-ones-aligned to 0 is silent.
- Redirect (branch_valid_i=1, any non-reset state):
  - Redirect overrides stall and overrides BOOT/FLUSH counting.
  - PC <= branch_target_i with the low log2(INSTR_BYTES) bits forced to 0.
  - misaligned_o <= 1 if the discarded bits were nonzero, else 0. misaligned_o returns to 0 on the next cycle without a misaligned redirect.
  - If REDIRECT_BUBBLES>0: state<=FLUSH, count<=REDIRECT_BUBBLES. Else state<=RUN.
  - A redirect arriving during FLUSH restarts the count and retargets the PC (last redirect wins).
- BOOT/FLUSH:
  - PC holds and is_valid_o=0.
  - Count decrements only on cycles where stall_pipeline_i!=STALL_PIPELINE (bubbles are consumed as the pipe advances).
  - When count==1 and not stalled, the state goes to RUN the next cycle. The PC is not incremented on that transition, so the first valid fetch is exactly the held address.
- Latency: a redirect presented in cycle N gives program_counter_o=target in N+1, with is_valid_o=0 for REDIRECT_BUBBLES unstalled cycles, then valid.
- Reset mid-operation: reset_i dominates redirect and stall. All state is reinitialised the same cycle.
- Elaboration assertions: INSTR_BYTES is a power of two; RESET_ADDR % INSTR_BYTES == 0.

Decomposition:
- Shared package (GENERAL_DEFS): the pc_state_e enum {PC_BOOT, PC_RUN, PC_FLUSH}. stall_pipeline_sig and WORD stay where they are; ADDR_WIDTH defaults to WORD.
- Sub-module redirect_bubble_counter: load, decrement-enable and done for the shared 4-bit count. This keeps the FSM in the top level purely next-state logic.

Test Plan:
- Reset with defaults, 4 unstalled cycles -> PC 0,2,4,6,8; is_valid_o=1 throughout; misaligned_o=0.
- Stall asserted at PC=0x10 for 3 cycles -> PC holds 0x10 for 3 cycles, then 0x12; is_valid_o stays 1.
- Redirect to 0x100 at PC=0x20 with REDIRECT_BUBBLES=2 -> next cycle PC=0x100 with is_valid_o=0 for 2 cycles, then 0x100 valid, then 0x102.
- Redirect to 0x103 with stall asserted -> PC=0x102 next cycle, misaligned_o=1 for exactly one cycle, and the redirect is not blocked by the stall.
- Redirect to 0x200 during FLUSH from an earlier redirect, with stalls interleaved -> PC=0x200, the bubble count restarts, and stalled cycles do not consume bubbles.
- ADDR_WIDTH=8, INSTR_BYTES=4, PC=0xFC unstalled -> PC wraps to 0x00. Also assert reset mid-FLUSH -> PC=RESET_ADDR next cycle with no residual bubbles when BOOT_WAIT=0.

Source files
------------

// File: rtl/fetch_program_counter_pkg.sv
// Shared fetch-stage definitions: machine word, pipeline stall encoding and
// the program counter state set used by the fetch front end.
package GENERAL_DEFS;

  // Native machine word; fetch addresses default to this width.
  localparam int WORD = 32;

  // Pipeline stall signalling, with the level that means "hold the pipe".
  typedef logic stall_pipeline_sig;
  localparam stall_pipeline_sig STALL_PIPELINE = 1'b1;

  // Program counter operating states.
  // PC_BOOT  : waiting out the post-reset settle window, no valid fetch yet
  // PC_RUN   : fetching, PC advances whenever the pipe is not stalled
  // PC_FLUSH : instruction memory is refetching after a redirect
  typedef enum logic [1:0] {
    PC_BOOT  = 2'd0,
    PC_RUN   = 2'd1,
    PC_FLUSH = 2'd2
  } pc_state_e;

  // Width of the shared boot/flush bubble counter (holds 0..15).
  localparam int BUBBLE_COUNT_WIDTH = 4;

  // True when value is a nonzero power of two.
  function automatic logic is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_program_counter_redirect_bubble_counter.sv
// Shared down-counter for the boot settle window and the post-redirect
// bubble window. The owner loads a count, enables decrements on cycles
// where a bubble is consumed, and watches done_o to know that the current
// cycle is the final invalid one.
module redirect_bubble_counter
  import GENERAL_DEFS::*;
#(
  parameter logic [BUBBLE_COUNT_WIDTH-1:0] RESET_COUNT = '0
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          load_i,
  input  logic [BUBBLE_COUNT_WIDTH-1:0] load_value_i,
  input  logic                          dec_i,
  output logic                          done_o
);

  logic [BUBBLE_COUNT_WIDTH-1:0] count_q;

  // Reset to the boot window, reload on redirect, otherwise count down to zero.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= RESET_COUNT;
    end else if (load_i) begin
      count_q <= load_value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - BUBBLE_COUNT_WIDTH'(1);
    end
  end

  // The last bubble is the one being consumed while the count reads one.
  assign done_o = (count_q == BUBBLE_COUNT_WIDTH'(1));

endmodule

// File: rtl/fetch_program_counter.sv
// Instruction-fetch program counter. Produces the registered fetch address
// and a fetch-valid flag for the head of the fetch stage. Handles sequential
// advance with pipeline stalls, branch redirects with alignment checking,
// a post-reset boot window and a post-redirect bubble window while the
// instruction memory refetches.
module fetch_program_counter
  import GENERAL_DEFS::*;
#(
  parameter int unsigned           ADDR_WIDTH       = WORD,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR       = '0,
  parameter int unsigned           INSTR_BYTES      = 2,
  parameter int unsigned           REDIRECT_BUBBLES = 1,
  parameter int unsigned           BOOT_WAIT        = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  stall_pipeline_sig     stall_pipeline_i,
  input  logic                  branch_valid_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  output logic [ADDR_WIDTH-1:0] program_counter_o,
  output logic                  is_valid_o,
  output logic                  misaligned_o
);

  // Number of address bits inside one instruction; these are dropped on redirect.
  localparam int unsigned OFFSET_BITS = $clog2(INSTR_BYTES);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(INSTR_BYTES);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);

  localparam logic [BUBBLE_COUNT_WIDTH-1:0] BOOT_COUNT     = BUBBLE_COUNT_WIDTH'(BOOT_WAIT);
  localparam logic [BUBBLE_COUNT_WIDTH-1:0] REDIRECT_COUNT = BUBBLE_COUNT_WIDTH'(REDIRECT_BUBBLES);

  // With no boot window the first cycle after reset already fetches.
  localparam pc_state_e RESET_STATE = (BOOT_WAIT > 0) ? PC_BOOT : PC_RUN;

  // A redirect with no bubbles goes straight back to fetching.
  localparam pc_state_e REDIRECT_STATE = (REDIRECT_BUBBLES > 0) ? PC_FLUSH : PC_RUN;

  // Reject parameter sets that would produce a misbehaving counter.
  if (!is_pow2(INSTR_BYTES) || ((INSTR_BYTES != 2) && (INSTR_BYTES != 4))) begin : g_bad_instr_bytes
    $error("fetch_program_counter: INSTR_BYTES must be a power of two, 2 or 4");
  end
  if ((RESET_ADDR & OFFSET_MASK) != '0) begin : g_bad_reset_addr
    $error("fetch_program_counter: RESET_ADDR must be INSTR_BYTES-aligned");
  end
  if (REDIRECT_BUBBLES > 15) begin : g_bad_redirect_bubbles
    $error("fetch_program_counter: REDIRECT_BUBBLES must be in 0..15");
  end
  if (BOOT_WAIT > 15) begin : g_bad_boot_wait
    $error("fetch_program_counter: BOOT_WAIT must be in 0..15");
  end

  pc_state_e             state_q;
  pc_state_e             state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic                  misaligned_q;
  logic                  misaligned_d;

  logic                   stalled;
  logic [ADDR_WIDTH-1:0]  aligned_target;
  logic [OFFSET_BITS-1:0] target_offset;
  logic                   count_load;
  logic                   count_dec;
  logic                   count_done;

  assign stalled        = (stall_pipeline_i == STALL_PIPELINE);
  assign aligned_target = branch_target_i & ~OFFSET_MASK;
  assign target_offset  = branch_target_i[OFFSET_BITS-1:0];

  // Every redirect restarts the bubble window; bubbles drain only while the
  // pipe moves, and a redirect cycle never counts as a consumed bubble.
  assign count_load = branch_valid_i;
  assign count_dec  = (state_q != PC_RUN) && !stalled && !branch_valid_i;

  redirect_bubble_counter #(
    .RESET_COUNT (BOOT_COUNT)
  ) u_bubble_counter (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .load_i       (count_load),
    .load_value_i (REDIRECT_COUNT),
    .dec_i        (count_dec),
    .done_o       (count_done)
  );

  // Next state: redirects dominate; waiting states leave once the last bubble drains.
  always_comb begin
    state_d = state_q;
    if (branch_valid_i) begin
      state_d = REDIRECT_STATE;
    end else begin
      case (state_q)
        PC_BOOT, PC_FLUSH: begin
          if (!stalled && count_done) begin
            state_d = PC_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Next PC: take the aligned redirect target, else step only while fetching unstalled.
  always_comb begin
    pc_d = pc_q;
    if (branch_valid_i) begin
      pc_d = aligned_target;
    end else if ((state_q == PC_RUN) && !stalled) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // Flag a redirect whose target had offset bits set; clears on any other cycle.
  always_comb begin
    misaligned_d = 1'b0;
    if (branch_valid_i && (target_offset != '0)) begin
      misaligned_d = 1'b1;
    end
  end

  // State registers; reset dominates every other request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= RESET_STATE;
      pc_q         <= RESET_ADDR;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign program_counter_o = pc_q;
  assign is_valid_o        = (state_q == PC_RUN);
  assign misaligned_o      = misaligned_q;

endmodule

// File: tb/tb_fetch_program_counter.sv
// Bench for fetch_program_counter. Two instances share stimulus: a 32-bit
// thumb-style PC with two redirect bubbles and no boot window, and an 8-bit
// word-sized PC with a boot window for wrap and alignment cases.
module tb_fetch_program_counter;
  import GENERAL_DEFS::*;

  localparam stall_pipeline_sig STALL = STALL_PIPELINE;
  localparam stall_pipeline_sig GO    = ~STALL_PIPELINE;

  localparam int unsigned A_AW = 32, A_IB = 2, A_RB = 2, A_BW = 0;
  localparam longint unsigned A_RST = 64'h0;
  localparam int unsigned B_AW = 8, B_IB = 4, B_RB = 1, B_BW = 2;
  localparam longint unsigned B_RST = 64'hF0;

  logic              clk = 1'b0;
  logic              reset;
  stall_pipeline_sig stall;
  logic              branch_valid;
  logic [31:0]       target;

  logic [31:0] pc_a;
  logic        valid_a, mis_a;
  logic [7:0]  pc_b;
  logic        valid_b, mis_b;

  int total = 0;
  int bad   = 0;

  // Reference model state for the random phase.
  longint unsigned ma_pc, mb_pc;
  int              ma_bub, mb_bub;
  bit              ma_mis, mb_mis;

  always #5 clk = ~clk;

  fetch_program_counter #(
    .ADDR_WIDTH(32), .RESET_ADDR(32'h0), .INSTR_BYTES(2),
    .REDIRECT_BUBBLES(2), .BOOT_WAIT(0)
  ) dut_a (
    .clk_i(clk), .reset_i(reset), .stall_pipeline_i(stall),
    .branch_valid_i(branch_valid), .branch_target_i(target),
    .program_counter_o(pc_a), .is_valid_o(valid_a), .misaligned_o(mis_a)
  );

  fetch_program_counter #(
    .ADDR_WIDTH(8), .RESET_ADDR(8'hF0), .INSTR_BYTES(4),
    .REDIRECT_BUBBLES(1), .BOOT_WAIT(2)
  ) dut_b (
    .clk_i(clk), .reset_i(reset), .stall_pipeline_i(stall),
    .branch_valid_i(branch_valid), .branch_target_i(target[7:0]),
    .program_counter_o(pc_b), .is_valid_o(valid_b), .misaligned_o(mis_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural model: remaining invalid cycles plus the fetch address.
  task automatic model_step(input int unsigned aw, input int unsigned ib,
                            input int unsigned rb, input int unsigned bw,
                            input longint unsigned rst_addr,
                            input bit rst, input bit stl, input bit br,
                            input longint unsigned tgt,
                            inout longint unsigned pc, inout int bub, inout bit mis);
    longint unsigned mask;
    mask = (64'd1 << aw) - 64'd1;
    if (rst) begin
      pc = rst_addr; bub = int'(bw); mis = 1'b0;
    end else if (br) begin
      pc  = (tgt & mask) - ((tgt & mask) % longint'(ib));
      mis = ((tgt % longint'(ib)) != 0);
      bub = int'(rb);
    end else begin
      mis = 1'b0;
      if (bub > 0) begin
        if (!stl) bub = bub - 1;
      end else if (!stl) begin
        pc = (pc + longint'(ib)) & mask;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = GO; branch_valid = 1'b0; target = '0;
    tick(); tick();
    total++; if (pc_a !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc_a got=%h want=%h", pc_a, 32'h0); end
    total++; if (valid_a !== 1'b1) begin bad++; $display("[TB] FAIL reset_valid_a got=%b want=1", valid_a); end
    total++; if (mis_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_mis_a got=%b want=0", mis_a); end
    total++; if (pc_b !== 8'hF0) begin bad++; $display("[TB] FAIL reset_pc_b got=%h want=f0", pc_b); end
    total++; if (valid_b !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid_b got=%b want=0", valid_b); end
  endtask

  task automatic test_sequential();
    logic [7:0] want_b;
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      want_b = (i >= 2) ? 8'(8'hF0 + 4 * (i - 2)) : 8'hF0;
      total++; if (pc_a !== 32'(2 * i)) begin bad++; $display("[TB] FAIL seq_pc_a[%0d] got=%h want=%h", i, pc_a, 32'(2 * i)); end
      total++; if (valid_a !== 1'b1 || mis_a !== 1'b0) begin bad++; $display("[TB] FAIL seq_flags_a[%0d] got=%b%b want=10", i, valid_a, mis_a); end
      total++; if (valid_b !== (i >= 2)) begin bad++; $display("[TB] FAIL boot_valid_b[%0d] got=%b want=%b", i, valid_b, (i >= 2)); end
      total++; if (pc_b !== want_b) begin bad++; $display("[TB] FAIL boot_pc_b[%0d] got=%h want=%h", i, pc_b, want_b); end
    end
  endtask

  task automatic test_stall();
    repeat (4) tick();
    total++; if (pc_a !== 32'h10) begin bad++; $display("[TB] FAIL stall_setup got=%h want=10", pc_a); end
    stall = STALL;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc_a !== 32'h10 || valid_a !== 1'b1) begin bad++; $display("[TB] FAIL stall_hold[%0d] got=%h/%b want=10/1", i, pc_a, valid_a); end
    end
    stall = GO;
    tick();
    total++; if (pc_a !== 32'h12) begin bad++; $display("[TB] FAIL stall_release got=%h want=12", pc_a); end
  endtask

  task automatic test_redirect();
    logic [31:0] want_pc [4] = '{32'h100, 32'h100, 32'h100, 32'h102};
    logic        want_v  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    repeat (7) tick();
    total++; if (pc_a !== 32'h20) begin bad++; $display("[TB] FAIL redirect_setup got=%h want=20", pc_a); end
    branch_valid = 1'b1; target = 32'h100;
    for (int i = 0; i < 4; i++) begin
      tick();
      branch_valid = 1'b0;
      total++; if (pc_a !== want_pc[i] || valid_a !== want_v[i] || mis_a !== 1'b0) begin
        bad++; $display("[TB] FAIL redirect[%0d] got=%h/%b/%b want=%h/%b/0", i, pc_a, valid_a, mis_a, want_pc[i], want_v[i]);
      end
    end
  endtask

  task automatic test_misaligned_stall();
    stall = STALL; branch_valid = 1'b1; target = 32'h103;
    tick();
    stall = GO; branch_valid = 1'b0;
    total++; if (pc_a !== 32'h102 || mis_a !== 1'b1 || valid_a !== 1'b0) begin
      bad++; $display("[TB] FAIL misaligned_hit got=%h/%b/%b want=102/1/0", pc_a, mis_a, valid_a);
    end
    tick();
    total++; if (pc_a !== 32'h102 || mis_a !== 1'b0 || valid_a !== 1'b0) begin
      bad++; $display("[TB] FAIL misaligned_clear got=%h/%b/%b want=102/0/0", pc_a, mis_a, valid_a);
    end
    tick();
    total++; if (pc_a !== 32'h102 || valid_a !== 1'b1) begin bad++; $display("[TB] FAIL misaligned_resume got=%h/%b want=102/1", pc_a, valid_a); end
  endtask

  task automatic test_redirect_during_flush();
    stall_pipeline_sig seq_stall [5] = '{STALL, STALL, GO, STALL, GO};
    logic              seq_valid [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    branch_valid = 1'b1; target = 32'h180;
    tick();
    branch_valid = 1'b0;
    total++; if (pc_a !== 32'h180 || valid_a !== 1'b0) begin bad++; $display("[TB] FAIL flush_first got=%h/%b want=180/0", pc_a, valid_a); end
    tick();
    total++; if (valid_a !== 1'b0) begin bad++; $display("[TB] FAIL flush_mid got=%b want=0", valid_a); end
    branch_valid = 1'b1; target = 32'h200; stall = STALL;
    tick();
    branch_valid = 1'b0;
    total++; if (pc_a !== 32'h200 || valid_a !== 1'b0) begin bad++; $display("[TB] FAIL flush_retarget got=%h/%b want=200/0", pc_a, valid_a); end
    for (int i = 0; i < 5; i++) begin
      stall = seq_stall[i];
      tick();
      total++; if (pc_a !== 32'h200 || valid_a !== seq_valid[i]) begin
        bad++; $display("[TB] FAIL flush_restart[%0d] got=%h/%b want=200/%b", i, pc_a, valid_a, seq_valid[i]);
      end
    end
    stall = GO;
    tick();
    total++; if (pc_a !== 32'h202 || valid_a !== 1'b1) begin bad++; $display("[TB] FAIL flush_advance got=%h/%b want=202/1", pc_a, valid_a); end
  endtask

  task automatic test_reset_mid_flush();
    branch_valid = 1'b1; target = 32'h300;
    tick();
    total++; if (valid_a !== 1'b0) begin bad++; $display("[TB] FAIL rstflush_enter got=%b want=0", valid_a); end
    reset = 1'b1; branch_valid = 1'b1; target = 32'h401; stall = STALL;
    tick();
    total++; if (pc_a !== 32'h0 || valid_a !== 1'b1 || mis_a !== 1'b0) begin
      bad++; $display("[TB] FAIL rstflush_reset got=%h/%b/%b want=0/1/0", pc_a, valid_a, mis_a);
    end
    reset = 1'b0; branch_valid = 1'b0; stall = GO;
    tick();
    total++; if (pc_a !== 32'h2 || valid_a !== 1'b1) begin bad++; $display("[TB] FAIL rstflush_after got=%h/%b want=2/1", pc_a, valid_a); end
  endtask

  task automatic test_wrap();
    logic [7:0] want_pc [6] = '{8'hF0, 8'hF4, 8'hF8, 8'hFC, 8'h00, 8'h04};
    reset = 1'b1; stall = GO; branch_valid = 1'b0;
    tick();
    reset = 1'b0; stall = STALL;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (valid_b !== 1'b0 || pc_b !== 8'hF0) begin bad++; $display("[TB] FAIL boot_stall[%0d] got=%h/%b want=f0/0", i, pc_b, valid_b); end
    end
    stall = GO;
    tick();
    total++; if (valid_b !== 1'b0) begin bad++; $display("[TB] FAIL boot_last got=%b want=0", valid_b); end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (pc_b !== want_pc[i] || valid_b !== 1'b1) begin bad++; $display("[TB] FAIL wrap[%0d] got=%h/%b want=%h/1", i, pc_b, valid_b, want_pc[i]); end
    end
    branch_valid = 1'b1; target = 32'h33;
    tick();
    branch_valid = 1'b0;
    total++; if (pc_b !== 8'h30 || mis_b !== 1'b1 || valid_b !== 1'b0) begin
      bad++; $display("[TB] FAIL word_misalign got=%h/%b/%b want=30/1/0", pc_b, mis_b, valid_b);
    end
    tick();
    total++; if (pc_b !== 8'h30 || mis_b !== 1'b0 || valid_b !== 1'b1) begin
      bad++; $display("[TB] FAIL word_resume got=%h/%b/%b want=30/0/1", pc_b, mis_b, valid_b);
    end
  endtask

  task automatic test_random();
    bit stl;
    reset = 1'b1; stall = GO; branch_valid = 1'b0;
    model_step(A_AW, A_IB, A_RB, A_BW, A_RST, 1'b1, 1'b0, 1'b0, 0, ma_pc, ma_bub, ma_mis);
    model_step(B_AW, B_IB, B_RB, B_BW, B_RST, 1'b1, 1'b0, 1'b0, 0, mb_pc, mb_bub, mb_mis);
    tick();
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 49) == 0);
      stall        = ($urandom_range(0, 9) < 3) ? STALL : GO;
      branch_valid = ($urandom_range(0, 6) == 0);
      target       = $urandom;
      stl          = (stall == STALL_PIPELINE);
      model_step(A_AW, A_IB, A_RB, A_BW, A_RST, reset, stl, branch_valid, longint'(target), ma_pc, ma_bub, ma_mis);
      model_step(B_AW, B_IB, B_RB, B_BW, B_RST, reset, stl, branch_valid, longint'(target[7:0]), mb_pc, mb_bub, mb_mis);
      tick();
      total++; if (pc_a !== 32'(ma_pc)) begin bad++; $display("[TB] FAIL rand_pc_a[%0d] got=%h want=%h", i, pc_a, 32'(ma_pc)); end
      total++; if (valid_a !== (ma_bub == 0)) begin bad++; $display("[TB] FAIL rand_valid_a[%0d] got=%b want=%b", i, valid_a, (ma_bub == 0)); end
      total++; if (mis_a !== ma_mis) begin bad++; $display("[TB] FAIL rand_mis_a[%0d] got=%b want=%b", i, mis_a, ma_mis); end
      total++; if (pc_b !== 8'(mb_pc)) begin bad++; $display("[TB] FAIL rand_pc_b[%0d] got=%h want=%h", i, pc_b, 8'(mb_pc)); end
      total++; if (valid_b !== (mb_bub == 0)) begin bad++; $display("[TB] FAIL rand_valid_b[%0d] got=%b want=%b", i, valid_b, (mb_bub == 0)); end
      total++; if (mis_b !== mb_mis) begin bad++; $display("[TB] FAIL rand_mis_b[%0d] got=%b want=%b", i, mis_b, mb_mis); end
    end
    reset = 1'b0; branch_valid = 1'b0; stall = GO;
  endtask

  initial begin
    $display("[TB] fetch_program_counter bench start");
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misaligned_stall();
    test_redirect_during_flush();
    test_reset_mid_flush();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
